// File: rtl/bitty_pkg.sv
// rtl/bitty_pkg.sv - shared types and constants for the Bitty instruction sequencer
package bitty_pkg;

    localparam int INSTR_W              = 16;
    localparam int CNT_W                = 16;
    localparam int NOMINAL_INSTR_CYCLES = 7;
    localparam int CU_DONE_LATENCY      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_MEMWAIT,
        ST_ISSUE,
        ST_LOAD,
        ST_CALC,
        ST_WAIT_DONE,
        ST_HALTED
    } seq_state_t;

    // Retired-instruction counter increment that sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bitty_watchdog.sv
// rtl/bitty_watchdog.sv - cycle watchdog that pulses when a wait runs TIMEOUT cycles
module bitty_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    // Expiry is reported on the TIMEOUT-th enabled cycle, so the caller acts on that edge
    assign o_expired = i_en && (r_cnt == CW'(TIMEOUT - 1));

    // Count enabled cycles; clearing restarts the window for the next wait
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bitty_instr_sequencer.sv
// rtl/bitty_instr_sequencer.sv - fetch/issue sequencer driving the Bitty control unit
module bitty_instr_sequencer
    import bitty_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               halt_req,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W-1:0]  end_addr,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               en_i,
    output logic               en_s,
    output logic               en_c,
    input  logic               cu_done,
    output logic               busy,
    output logic               finished,
    output logic [ADDR_W-1:0]  pc,
    output logic [CNT_W-1:0]   instr_count,
    output logic               err_timeout
);

    seq_state_t         r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_end;
    logic [INSTR_W-1:0] r_instr;
    logic [CNT_W-1:0]   r_count;
    logic               r_rd_en;
    logic               r_en_i;
    logic               r_en_s;
    logic               r_en_c;
    logic               r_busy;
    logic               r_finished;
    logic               r_err;
    logic               r_halt_seen;

    logic               w_wd_en;
    logic               w_wd_clear;
    logic               w_wd_expired;
    logic               w_halt;
    logic               w_last;

    assign w_wd_en    = (r_state == ST_WAIT_DONE) && !cu_done;
    assign w_wd_clear = (r_state != ST_WAIT_DONE);
    assign w_halt     = r_halt_seen || halt_req;
    assign w_last     = (r_pc == r_end);

    assign imem_rd_en  = r_rd_en;
    assign imem_addr   = r_pc;
    assign instruction = r_instr;
    assign en_i        = r_en_i;
    assign en_s        = r_en_s;
    assign en_c        = r_en_c;
    assign busy        = r_busy;
    assign finished    = r_finished;
    assign pc          = r_pc;
    assign instr_count = r_count;
    assign err_timeout = r_err;

    bitty_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_clear   (w_wd_clear),
        .i_en      (w_wd_en),
        .o_expired (w_wd_expired)
    );

    // Sequencer FSM; every output is registered and the one-cycle strobes default low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_end       <= '0;
            r_instr     <= '0;
            r_count     <= '0;
            r_rd_en     <= 1'b0;
            r_en_i      <= 1'b0;
            r_en_s      <= 1'b0;
            r_en_c      <= 1'b0;
            r_busy      <= 1'b0;
            r_finished  <= 1'b0;
            r_err       <= 1'b0;
            r_halt_seen <= 1'b0;
        end else begin
            r_rd_en    <= 1'b0;
            r_en_i     <= 1'b0;
            r_en_s     <= 1'b0;
            r_en_c     <= 1'b0;
            r_finished <= 1'b0;
            // A halt request anywhere inside an instruction is remembered until it retires
            if (r_busy && halt_req) begin
                r_halt_seen <= 1'b1;
            end
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        r_state     <= ST_FETCH;
                        r_pc        <= base_addr;
                        r_end       <= end_addr;
                        r_count     <= '0;
                        r_err       <= 1'b0;
                        r_halt_seen <= 1'b0;
                        r_rd_en     <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_MEMWAIT;
                end
                ST_MEMWAIT: begin
                    r_instr <= imem_rdata;
                    r_state <= ST_ISSUE;
                    r_en_i  <= 1'b1;
                end
                ST_ISSUE: begin
                    r_state <= ST_LOAD;
                    r_en_s  <= 1'b1;
                end
                ST_LOAD: begin
                    r_state <= ST_CALC;
                    r_en_c  <= 1'b1;
                end
                ST_CALC: begin
                    r_state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (cu_done) begin
                        r_count     <= sat_inc(r_count);
                        r_halt_seen <= 1'b0;
                        if (w_last) begin
                            // End of range takes priority over a pending halt
                            r_state    <= ST_IDLE;
                            r_finished <= 1'b1;
                            r_busy     <= 1'b0;
                        end else if (w_halt) begin
                            r_state <= ST_HALTED;
                            r_pc    <= r_pc + 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= ST_FETCH;
                            r_pc    <= r_pc + 1'b1;
                            r_rd_en <= 1'b1;
                        end
                    end else if (w_wd_expired) begin
                        r_state <= ST_HALTED;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bitty_instr_sequencer.md
Name: bitty_instr_sequencer

Overview:
Program sequencer for the Bitty processor core. Fetches 16-bit instructions from a synchronous instruction memory over an address range. Drives each instruction through the control unit's en_i / en_s / en_c handshake and waits for its done pulse. Counts retired instructions, supports a graceful halt, and flags a hung core with a watchdog.

Parameters:
ADDR_W, 8, instruction-memory address width; PC wraps modulo 2^ADDR_W.
TIMEOUT, 16, maximum cycles in WAIT_DONE before the watchdog fires.

Ports:
clk  in  1  system clock; one clock domain.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; begins a run from base_addr. Ignored unless state is IDLE or HALTED.
halt_req  in  1  request to stop after the current instruction retires.
base_addr  in  ADDR_W  first instruction address, sampled on start.
end_addr  in  ADDR_W  last instruction address, sampled on start.
imem_rd_en  out  1  memory read strobe.
imem_addr  out  ADDR_W  memory read address.
imem_rdata  in  16  read data; valid exactly one cycle after imem_rd_en.
instruction  out  16  instruction word to the control unit; held stable from ISSUE until the next fetch.
en_i  out  1  one-cycle pulse in ISSUE.
en_s  out  1  one-cycle pulse in LOAD.
en_c  out  1  one-cycle pulse in CALC.
cu_done  in  1  done pulse from the control unit.
busy  out  1  high in every state except IDLE and HALTED.
finished  out  1  one-cycle pulse when the instruction at end_addr retires.
pc  out  ADDR_W  address of the current instruction.
instr_count  out  16  retired-instruction count; saturates at 16'hFFFF.
err_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE and all outputs 0, including pc, instr_count, instruction, err_timeout and all enables. A reset mid-run aborts the run immediately with no completion pulse.
- States: IDLE, FETCH, MEMWAIT, ISSUE, LOAD, CALC, WAIT_DONE, HALTED.
- IDLE/HALTED -> FETCH on start:
  - pc<=base_addr; end_addr is latched.
  - instr_count<=0 and err_timeout<=0.
- FETCH: imem_rd_en=1, imem_addr=pc. Next state MEMWAIT.
- MEMWAIT: imem_rdata is captured into the instruction register at the clock edge. Next state ISSUE.
- ISSUE: en_i=1 -> LOAD.
- LOAD: en_s=1 -> CALC.
- CALC: en_c=1 -> WAIT_DONE.
- WAIT_DONE: hold until cu_done=1. The nominal wait is 2 cycles, because the control unit passes through STORE and then DONE.
- Retire, at the edge where cu_done=1 in WAIT_DONE:
  - instr_count increments (saturating).
  - If pc==end_addr: pulse finished, go to IDLE, pc holds.
  - Else if halt_req was seen at any time since ISSUE, or halt_req=1 now: go to HALTED with pc<=pc+1.
  - Else: pc<=pc+1 (mod 2^ADDR_W) and go to FETCH.
- Nominal cost is 7 cycles per instruction, FETCH to the next FETCH.
- Halt:
  - Never aborts an in-flight instruction.
  - halt_req in FETCH or MEMWAIT still lets that instruction complete.
  - halt_req while IDLE or HALTED has no effect.
  - A simultaneous end_addr retire and halt_req goes to IDLE with finished asserted; end-of-range wins.
- Wrap: when base_addr>end_addr the run wraps through 2^ADDR_W-1 to 0. When base_addr==end_addr exactly one instruction executes.
- Watchdog:
  - Counts cycles in WAIT_DONE without cu_done.
  - On reaching TIMEOUT: err_timeout<=1, state<=HALTED, instruction not counted.
  - err_timeout is cleared only by reset or a new start.
- A cu_done pulse outside WAIT_DONE is ignored.
- Enables are mutually exclusive and never asserted outside their named state.

Decomposition:
- Package bitty_pkg:
  - enumerated seq_state_t for the eight states.
  - INSTR_W=16 and CNT_W=16.
  - localparams for the nominal per-instruction latency (7) and the control-unit done latency (2).
- One sub-module, bitty_watchdog:
  - Inputs: clear, count-enable, TIMEOUT parameter.
  - Output: expired pulse.
  - Instantiated once, enabled only in WAIT_DONE.

Test Plan:
1. base=end=5, imem[5]=16'h1234, model control unit returns cu_done 2 cycles after en_c -> one imem read at address 5; instruction=16'h1234 during en_i; en_i, en_s, en_c each high exactly 1 cycle in consecutive cycles; finished 7 cycles after start; instr_count=1; busy drops to 0.
2. base=0, end=3 -> reads at 0,1,2,3 spaced 7 cycles apart; 4 en_i pulses; instr_count=4; single finished pulse; pc=3 at end.
3. ADDR_W=8, base=254, end=1 -> fetch order 254,255,0,1; instr_count=4; finished asserted.
4. base=0, end=9, halt_req pulsed while second instruction is in LOAD -> second instruction retires; state HALTED; pc=2; instr_count=2; no finished. A later start with base=2 resumes at address 2.
5. cu_done tied 0 -> err_timeout=1 after 16 cycles in WAIT_DONE; state HALTED; instr_count=0. A new start clears err_timeout.
6. reset asserted in CALC of instruction 3 -> all outputs 0 asynchronously, before the next clock edge; state IDLE; no finished pulse; a later start runs cleanly from base_addr.
